// File: rtl/board_state_if.sv
// Move request / response channel between a move source and the board_state engine.
// The master issues coordinates under move_valid; the slave answers with done/err pulses.
interface board_state_if;
    logic       move_valid;
    logic       move_ready;
    logic [2:0] from_row;
    logic [2:0] from_col;
    logic [2:0] to_row;
    logic [2:0] to_col;
    logic       move_done;
    logic       move_err;
    logic [1:0] err_code;

    modport master (
        output move_valid, from_row, from_col, to_row, to_col,
        input  move_ready, move_done, move_err, err_code
    );

    modport slave (
        input  move_valid, from_row, from_col, to_row, to_col,
        output move_ready, move_done, move_err, err_code
    );
endinterface

// File: rtl/board_state.sv
// Authoritative 8x8 checkers board and single-hop move engine feeding the board renderer.
// Squares: bit0 occupied, bit1 black, bit2 king; one move in flight at a time.
module board_state #(
    parameter int unsigned PIECES = 12
) (
    input  logic         clk,
    input  logic         reset_b,
    input  logic         new_game,
    board_state_if.slave bus,
    output logic         turn,
    output logic         game_over,
    output logic         winner,
    output logic [2:0]   board_pos [7:0][7:0]
);
    typedef logic [2:0] board_t [7:0][7:0];
    typedef enum logic [2:0] {StIdle, StRead, StCheck, StCommit, StReject} state_e;

    localparam logic [3:0] PiecesInit = 4'(PIECES);

    function automatic board_t init_board();
        board_t b;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                b[r[2:0]][c[2:0]] = 3'b000;
                if (r[0] ^ c[0]) begin
                    if (r < 3)      b[r[2:0]][c[2:0]] = 3'b011;
                    else if (r > 4) b[r[2:0]][c[2:0]] = 3'b001;
                end
            end
        end
        return b;
    endfunction

    state_e     state_q, state_d;
    board_t     board_q, board_d;
    logic       turn_q, turn_d;
    logic       over_q, over_d;
    logic       win_q, win_d;
    logic       ready_q, ready_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [1:0] err_code_q, err_code_d;
    logic [1:0] code_q, code_d;
    logic       jump_q, jump_d;
    logic [2:0] fr_q, fr_d, fc_q, fc_d, tr_q, tr_d, tc_q, tc_d;
    logic [2:0] src_q, src_d;
    logic       dst_occ_q, dst_occ_d;
    logic [1:0] mid_q, mid_d;
    logic [3:0] cnt_w_q, cnt_w_d, cnt_b_q, cnt_b_d;

    logic [2:0]        mid_r, mid_c;
    logic signed [3:0] dr, dc;
    logic [3:0]        adr, adc;
    logic              bad_dir, crown;
    logic [1:0]        check_code;

    assign mid_r = 3'(({1'b0, fr_q} + {1'b0, tr_q}) >> 1);
    assign mid_c = 3'(({1'b0, fc_q} + {1'b0, tc_q}) >> 1);
    assign dr    = $signed({1'b0, tr_q}) - $signed({1'b0, fr_q});
    assign dc    = $signed({1'b0, tc_q}) - $signed({1'b0, fc_q});
    assign adr   = dr[3] ? $unsigned(-dr) : $unsigned(dr);
    assign adc   = dc[3] ? $unsigned(-dc) : $unsigned(dc);
    // Men only advance: black towards row 7, white towards row 0.
    assign bad_dir = !src_q[2] && (turn_q ? dr[3] : !dr[3]);
    assign crown   = src_q[1] ? (tr_q == 3'd7) : (tr_q == 3'd0);

    always_comb begin
        check_code = 2'd0;
        if (!src_q[0] || (src_q[1] != turn_q)) begin
            check_code = 2'd1;
        end else if (dst_occ_q) begin
            check_code = 2'd2;
        end else if ((adr != adc) || !((adr == 4'd1) || (adr == 4'd2)) || bad_dir ||
                     ((adr == 4'd2) && !(mid_q[0] && (mid_q[1] != turn_q)))) begin
            check_code = 2'd3;
        end
    end

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        turn_d     = turn_q;
        over_d     = over_q;
        win_d      = win_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        code_d     = code_q;
        jump_d     = jump_q;
        fr_d       = fr_q;
        fc_d       = fc_q;
        tr_d       = tr_q;
        tc_d       = tc_q;
        src_d      = src_q;
        dst_occ_d  = dst_occ_q;
        mid_d      = mid_q;
        cnt_w_d    = cnt_w_q;
        cnt_b_d    = cnt_b_q;

        if (new_game) begin
            state_d    = StIdle;
            board_d    = init_board();
            turn_d     = 1'b1;
            over_d     = 1'b0;
            win_d      = 1'b0;
            err_code_d = 2'd0;
            cnt_w_d    = PiecesInit;
            cnt_b_d    = PiecesInit;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.move_valid && ready_q) begin
                        fr_d    = bus.from_row;
                        fc_d    = bus.from_col;
                        tr_d    = bus.to_row;
                        tc_d    = bus.to_col;
                        state_d = StRead;
                    end
                end
                StRead: begin
                    src_d     = board_q[fr_q][fc_q];
                    dst_occ_d = board_q[tr_q][tc_q][0];
                    mid_d     = board_q[mid_r][mid_c][1:0];
                    state_d   = StCheck;
                end
                StCheck: begin
                    code_d  = check_code;
                    jump_d  = (adr == 4'd2);
                    state_d = (check_code == 2'd0) ? StCommit : StReject;
                end
                StCommit: begin
                    board_d[tr_q][tc_q] = {src_q[2] | crown, src_q[1:0]};
                    board_d[fr_q][fc_q] = 3'b000;
                    if (jump_q) begin
                        board_d[mid_r][mid_c] = 3'b000;
                        if (turn_q) begin
                            if (cnt_w_q != 4'd0) cnt_w_d = cnt_w_q - 4'd1;
                            if (cnt_w_d == 4'd0) begin
                                over_d = 1'b1;
                                win_d  = turn_q;
                            end
                        end else begin
                            if (cnt_b_q != 4'd0) cnt_b_d = cnt_b_q - 4'd1;
                            if (cnt_b_d == 4'd0) begin
                                over_d = 1'b1;
                                win_d  = turn_q;
                            end
                        end
                    end
                    turn_d  = ~turn_q;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
                StReject: begin
                    err_d      = 1'b1;
                    err_code_d = code_q;
                    state_d    = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
        // Registered so move_ready rises in the same cycle as the done/err pulse.
        ready_d = (state_d == StIdle) && !over_d;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= StIdle;
            board_q    <= init_board();
            turn_q     <= 1'b1;
            over_q     <= 1'b0;
            win_q      <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            code_q     <= 2'd0;
            jump_q     <= 1'b0;
            fr_q       <= 3'd0;
            fc_q       <= 3'd0;
            tr_q       <= 3'd0;
            tc_q       <= 3'd0;
            src_q      <= 3'd0;
            dst_occ_q  <= 1'b0;
            mid_q      <= 2'd0;
            cnt_w_q    <= PiecesInit;
            cnt_b_q    <= PiecesInit;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            turn_q     <= turn_d;
            over_q     <= over_d;
            win_q      <= win_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            code_q     <= code_d;
            jump_q     <= jump_d;
            fr_q       <= fr_d;
            fc_q       <= fc_d;
            tr_q       <= tr_d;
            tc_q       <= tc_d;
            src_q      <= src_d;
            dst_occ_q  <= dst_occ_d;
            mid_q      <= mid_d;
            cnt_w_q    <= cnt_w_d;
            cnt_b_q    <= cnt_b_d;
        end
    end

    assign bus.move_ready = ready_q;
    assign bus.move_done  = done_q;
    assign bus.move_err   = err_q;
    assign bus.err_code   = err_code_q;
    assign turn           = turn_q;
    assign game_over      = over_q;
    assign winner         = win_q;
    assign board_pos      = board_q;
endmodule

// File: tb/tb_board_state.sv
// Bench for board_state: scripted and random moves scored against a rule-level checkers model.
// dut2 starts with one piece per side so a single capture ends the game.
module tb_board_state;
    typedef logic [2:0] board_t [7:0][7:0];
    typedef struct {
        logic       is_err;
        logic [1:0] code;
        board_t     board;
        logic       trn;
        logic       over;
        logic       win;
        int         cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset_b = 1'b0;
    logic   new_game = 1'b0;
    logic   turn1, over1, win1, turn2, over2, win2;
    board_t board1, board2;

    board_state_if if1();
    board_state_if if2();

    board_state #(.PIECES(12)) dut1 (
        .clk(clk), .reset_b(reset_b), .new_game(new_game), .bus(if1),
        .turn(turn1), .game_over(over1), .winner(win1), .board_pos(board1)
    );
    board_state #(.PIECES(1)) dut2 (
        .clk(clk), .reset_b(reset_b), .new_game(new_game), .bus(if2),
        .turn(turn2), .game_over(over2), .winner(win2), .board_pos(board2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     n_pass = 0;
    int     n_total = 0;
    exp_t   q[$];
    board_t m_board;
    logic   m_turn, m_over, m_win;
    logic [1:0] m_err;
    int     m_cnt[2];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
    endtask

    // Reference model: rules applied directly to a board array.
    task automatic model_reset(input int pieces);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                m_board[r][c] = ((r + c) % 2 == 1) ? ((r <= 2) ? 3'b011 : (r >= 5) ? 3'b001 : 3'b000)
                                                   : 3'b000;
        m_turn = 1'b1; m_over = 1'b0; m_win = 1'b0; m_err = 2'd0;
        m_cnt[0] = pieces; m_cnt[1] = pieces;
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int rule_code(input int fr, input int fc, input int tr, input int tc);
        logic [2:0] s, d, m;
        int dr, dc;
        s = m_board[fr][fc]; d = m_board[tr][tc];
        dr = tr - fr; dc = tc - fc;
        if (!s[0] || s[1] != m_turn) return 1;
        if (d[0]) return 2;
        if (iabs(dr) != iabs(dc) || iabs(dr) < 1 || iabs(dr) > 2) return 3;
        if (!s[2] && ((m_turn && dr < 0) || (!m_turn && dr > 0))) return 3;
        if (iabs(dr) == 2) begin
            m = m_board[(fr + tr) / 2][(fc + tc) / 2];
            if (!m[0] || m[1] == m_turn) return 3;
        end
        return 0;
    endfunction

    task automatic model_apply(input int fr, input int fc, input int tr, input int tc);
        logic [2:0] s;
        logic king;
        int opp;
        s = m_board[fr][fc];
        king = s[2] || (s[1] && tr == 7) || (!s[1] && tr == 0);
        m_board[tr][tc] = {king, s[1], 1'b1};
        m_board[fr][fc] = 3'b000;
        if (iabs(tr - fr) == 2) begin
            m_board[(fr + tr) / 2][(fc + tc) / 2] = 3'b000;
            opp = m_turn ? 0 : 1;
            if (m_cnt[opp] > 0) m_cnt[opp]--;
            if (m_cnt[opp] == 0) begin m_over = 1'b1; m_win = m_turn; end
        end
        m_turn = !m_turn;
    endtask

    function automatic logic rdy(input int s);
        return (s == 0) ? if1.move_ready : if2.move_ready;
    endfunction

    function automatic int board_diff(input int s, input board_t exp_b);
        int n = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (((s == 0) ? board1[r][c] : board2[r][c]) !== exp_b[r][c]) n++;
        return n;
    endfunction

    task automatic set_req(input int s, input logic v, input int fr, input int fc,
                           input int tr, input int tc);
        if (s == 0) begin
            if1.move_valid = v; if1.from_row = 3'(fr); if1.from_col = 3'(fc);
            if1.to_row = 3'(tr); if1.to_col = 3'(tc);
        end else begin
            if2.move_valid = v; if2.from_row = 3'(fr); if2.from_col = 3'(fc);
            if2.to_row = 3'(tr); if2.to_col = 3'(tc);
        end
    endtask

    // Issue one request, push the model's verdict, then watch move_ready through the move.
    task automatic issue(input int s, input int fr, input int fc, input int tr, input int tc);
        int   code;
        bit   got;
        exp_t x;
        @(negedge clk);
        set_req(s, 1'b1, fr, fc, tr, tc);
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (rdy(s)) got = 1;
            else @(negedge clk);
        end
        if (!got) begin
            fail("ready_timeout");
            set_req(s, 1'b0, 0, 0, 0, 0);
            return;
        end
        @(posedge clk);
        #1;
        code = rule_code(fr, fc, tr, tc);
        if (code == 0) model_apply(fr, fc, tr, tc);
        else m_err = 2'(code);
        x.is_err = (code != 0); x.code = m_err; x.board = m_board;
        x.trn = m_turn; x.over = m_over; x.win = m_win; x.cyc = cyc;
        q.push_back(x);
        @(negedge clk);
        set_req(s, 1'b0, 0, 0, 0, 0);
        check("ready_low_c1", rdy(s), 0);
        @(negedge clk);
        check("ready_low_c2", rdy(s), 0);
        @(negedge clk);
        check("ready_low_c3", rdy(s), 0);
        @(negedge clk);
        check("ready_back", rdy(s), !m_over);
        #1;
        if (q.size() != 0) begin
            fail("pulse_missing");
            q.delete();
        end
    endtask

    task automatic do_new_game(input int s, input int pieces);
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_reset(pieces);
        check("ng_ready", rdy(s), 1);
        check("ng_turn", (s == 0) ? turn1 : turn2, 1);
        check("ng_over", (s == 0) ? over1 : over2, 0);
    endtask

    always @(negedge clk) begin : monitor
        logic d, e, t, o, w;
        logic [1:0] ec;
        exp_t x;
        for (int s = 0; s < 2; s++) begin
            d  = (s == 0) ? if1.move_done : if2.move_done;
            e  = (s == 0) ? if1.move_err  : if2.move_err;
            ec = (s == 0) ? if1.err_code  : if2.err_code;
            t  = (s == 0) ? turn1 : turn2;
            o  = (s == 0) ? over1 : over2;
            w  = (s == 0) ? win1  : win2;
            if (reset_b && (d || e)) begin
                if (q.size() == 0) begin
                    fail($sformatf("unexpected_pulse_dut%0d", s + 1));
                end else begin
                    x = q.pop_front();
                    check("move_done", d, !x.is_err);
                    check("move_err", e, x.is_err);
                    check("err_code", ec, x.code);
                    check("turn", t, x.trn);
                    check("game_over", o, x.over);
                    check("winner", w, x.win);
                    check("board_squares_differing", board_diff(s, x.board), 0);
                    check("latency", cyc - x.cyc, 3);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cand[$];
        int fr, fc, tr, tc, p, row3;
        set_req(0, 1'b0, 0, 0, 0, 0);
        set_req(1, 1'b0, 0, 0, 0, 0);
        model_reset(12);
        #12 reset_b = 1'b1;
        @(negedge clk);
        check("rst_sq01", board1[0][1], 3);
        check("rst_sq50", board1[5][0], 1);
        row3 = 0;
        for (int c = 0; c < 8; c++) row3 += int'(board1[3][c]);
        check("rst_row3_sum", row3, 0);
        check("rst_turn", turn1, 1);
        check("rst_ready", if1.move_ready, 1);
        check("rst_over", over1, 0);
        check("rst_winner", win1, 0);
        check("rst_err_code", if1.err_code, 0);
        check("rst_pulses", {if1.move_done, if1.move_err}, 0);
        check("rst_board_squares_differing", board_diff(0, m_board), 0);

        // Scripted game on dut1.
        issue(0, 2, 1, 3, 0);
        check("step_src", board1[2][1], 0);
        check("step_dst", board1[3][0], 3);
        check("step_turn", turn1, 0);
        issue(0, 2, 3, 3, 2);
        check("err1_code", if1.err_code, 1);
        issue(0, 5, 0, 3, 2);
        check("err3_code", if1.err_code, 3);
        issue(0, 5, 4, 4, 3);
        check("err_code_held", if1.err_code, 3);
        issue(0, 2, 3, 3, 2);
        issue(0, 4, 3, 2, 1);
        check("cap_mid", board1[3][2], 0);
        check("cap_dst", board1[2][1], 1);
        issue(0, 0, 1, 1, 0);
        check("err2_code", if1.err_code, 2);
        issue(0, 1, 2, 2, 3);
        issue(0, 5, 0, 4, 1);
        issue(0, 0, 3, 1, 2);
        issue(0, 2, 1, 0, 3);
        check("promote_dst", board1[0][3], 5);
        issue(0, 2, 5, 3, 6);
        issue(0, 0, 3, 1, 2);
        check("king_back_dst", board1[1][2], 5);
        check("king_back_src", board1[0][3], 0);

        // new_game while the request is in CHECK: aborted with no pulse.
        @(negedge clk);
        set_req(0, 1'b1, 2, 7, 3, 6);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 0, 0, 0, 0);
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_reset(12);
        check("abort_pulses", {if1.move_done, if1.move_err}, 0);
        check("abort_ready", if1.move_ready, 1);
        check("abort_turn", turn1, 1);
        check("abort_board_squares_differing", board_diff(0, m_board), 0);
        @(negedge clk);
        check("abort_no_late_pulse", {if1.move_done, if1.move_err}, 0);

        // Random play against the model.
        for (int i = 0; i < 150; i++) begin
            cand.delete();
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    for (int d = 1; d <= 2; d++)
                        for (int k = 0; k < 4; k++) begin
                            tr = r + ((k[0]) ? d : -d);
                            tc = c + ((k[1]) ? d : -d);
                            if (tr >= 0 && tr < 8 && tc >= 0 && tc < 8 && rule_code(r, c, tr, tc) == 0)
                                cand.push_back((r << 9) | (c << 6) | (tr << 3) | tc);
                        end
            if (m_over || cand.size() == 0) begin
                do_new_game(0, 12);
            end else begin
                if ($urandom_range(0, 2) != 0) begin
                    p = cand[$urandom_range(0, cand.size() - 1)];
                    fr = (p >> 9) & 7; fc = (p >> 6) & 7; tr = (p >> 3) & 7; tc = p & 7;
                end else begin
                    fr = $urandom_range(0, 7); fc = $urandom_range(0, 7);
                    tr = $urandom_range(0, 7); tc = $urandom_range(0, 7);
                end
                issue(0, fr, fc, tr, tc);
            end
        end

        // dut2: one capture of black's only counted piece ends the game.
        do_new_game(1, 1);
        issue(1, 2, 1, 3, 2);
        issue(1, 5, 4, 4, 3);
        issue(1, 2, 5, 3, 6);
        issue(1, 4, 3, 2, 1);
        check("end_over", over2, 1);
        check("end_winner_white", win2, 0);
        check("end_ready", if2.move_ready, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            set_req(1, 1'b1, 2, 3, 3, 4);
            check("over_ready_low", if2.move_ready, 0);
        end
        @(negedge clk);
        set_req(1, 1'b0, 0, 0, 0, 0);
        @(negedge clk);
        check("over_board_squares_differing", board_diff(1, m_board), 0);
        check("over_turn", turn2, m_turn);
        do_new_game(1, 1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/board_state.md
Name: board_state

Overview:
- Authoritative 8x8 checkers board register and move engine, directly upstream of the VGA video generator.
- Drives the board_pos array (3-bit squares indexed [row][col]) consumed by the board renderer.
- Accepts move requests over a valid/ready handshake, checks legality, then commits: step, capture, promotion and turn change.
- One move in flight at a time.

Parameters:
- PIECES, 12, pieces per side at game start; width of the per-side counters is 4 bits.

Ports:
- clk  input  1  system clock
- reset_b  input  1  asynchronous active-low reset
- new_game  input  1  synchronous restart to initial layout
- move_valid  input  1  move request valid
- move_ready  output  1  engine can accept a request
- from_row  input  3  source row (0 = top of screen)
- from_col  input  3  source column
- to_row  input  3  destination row
- to_col  input  3  destination column
- move_done  output  1  one-cycle pulse, move committed
- move_err  output  1  one-cycle pulse, move rejected
- err_code  output  2  reason for the last rejection; held until the next move_err
- turn  output  1  side to move: 0 = white, 1 = black
- game_over  output  1  one side has no pieces left
- winner  output  1  valid when game_over; colour of the side with pieces left
- board_pos  output  3x8x8  unpacked [7:0][7:0] of 3-bit squares

Behaviour:
- Square encoding: bit0 occupied; bit1 colour (1 = black, 0 = white or empty); bit2 king. Empty = 3'b000.
- Dark square: (row+col) odd.
- Initial layout:
  - Rows 0-2: black men 3'b011 on dark squares.
  - Rows 5-7: white men 3'b001 on dark squares.
  - All other squares 3'b000.
- Reset (async, reset_b=0):
  - board = initial layout; turn=1 (black first); both counters = PIECES.
  - State IDLE; move_ready=1; move_done=0; move_err=0; err_code=0; game_over=0; winner=0.
- new_game=1 at a clock edge:
  - Same values as reset, applied synchronously.
  - Has priority over everything and aborts any in-flight move; no done/err pulse is produced.
- States: IDLE -> READ -> CHECK -> COMMIT -> IDLE; COMMIT is replaced by REJECT on failure.
  - IDLE: move_ready=1 iff game_over=0. Handshake = move_valid & move_ready at an edge; coordinates are latched at that edge.
  - READ (1 cycle): register the src square, dst square and mid square (mid = ((fr+tr)/2, (fc+tc)/2), used only for jumps).
  - CHECK (1 cycle): compute dr = tr-fr and dc = tc-fc as signed 4-bit values; evaluate the rules below in order, first failure wins.
    1. err 1: src unoccupied or src colour != turn.
    2. err 2: dst occupied.
    3. err 3: |dr| != |dc|, or |dr| not in {1,2}, or wrong direction for a man (black needs dr>0, white needs dr<0; kings may go either way), or |dr|=2 and mid is not occupied by the opponent.
  - COMMIT: at the edge leaving COMMIT:
    - dst <= src, with bit2 set if a black man lands on row 7 or a white man on row 0; src <= 0.
    - On a jump, mid <= 0 and the opponent counter decrements.
    - turn toggles.
    - If the decremented counter reaches 0: game_over <= 1, winner <= mover's colour.
  - REJECT: err_code <= code at the edge leaving REJECT; board and turn unchanged.
- Latency: handshake at edge E0 → board update, move_done/move_err visible in the cycle after E3, same cycle as move_ready=1 again. move_ready is low for exactly 3 cycles.
- move_valid while move_ready=0: ignored, no queueing.
- No multi-jump chaining and no forced capture; each request is one hop.
- All outputs are registered; board_pos is driven straight from the board registers.
- game_over=1: move_ready stays 0 and requests are ignored until new_game or reset.
- Counters never underflow; they saturate at 0.

Test Plan:
- Reset → board_pos[0][1]=3'b011, [5][0]=3'b001, [3][*]=0, turn=1, move_ready=1, game_over=0.
- Black move (2,1)->(3,0) → move_ready low 3 cycles, then move_done=1 for 1 cycle; [2][1]=0, [3][0]=3'b011, turn=0.
- Then white attempts (2,3)->(3,2) → move_err=1, err_code=1, board and turn unchanged; white (5,0)->(3,2) with empty mid → err_code=3.
- Scripted capture: white man at (4,3), black at (3,2), white jumps to (2,1) with [2][1] empty → [3][2]=0, [2][1]=3'b001, black count=11.
- Promotion: white man steps to row 0 → dst=3'b101. Then the king moves backward (row+1) → move_done, not err 3.
- new_game asserted during CHECK → no pulse next cycle, initial layout restored, turn=1, move_ready=1. Preloaded single-black-piece capture → game_over=1, winner=0, move_valid ignored.
